// File: rtl/bitops_scan_lo_enc.sv
// rtl/bitops_scan_lo_enc.sv - sequential lowest-set-bit scanner emitting set-bit indices lowest first
// Optional abort input enabled by defining BITOPS_SCAN_ABORT_EN.
module bitops_scan_lo_enc #(
    parameter int width = 8,
    parameter int idxw  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [width-1:0] load_data,
`ifdef BITOPS_SCAN_ABORT_EN
    input  logic             abort,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [idxw-1:0]  out_idx,
    output logic [width-1:0] out_onehot,
    output logic             out_last,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [width-1:0] rem_q, rem_d;
    logic             done_q, done_d;

    logic [width-1:0] lowbit;
    logic [width-1:0] rest;
    logic [idxw-1:0]  idx_v;
    logic             is_scan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        is_scan = (state_q == SCAN);
        lowbit  = rem_q & (~rem_q + width'(1));
        rest    = rem_q & (rem_q - width'(1));
        idx_v   = '0;
        for (int i = 0; i < width; i++) begin
            if (lowbit[i]) idx_v = idx_v | idxw'(i);
        end
    end

    // Gated by SCAN so idle outputs read as zero even though rem=0 would give out_last=1.
    always_comb begin
        load_ready = !is_scan;
        out_valid  = is_scan;
        out_onehot = is_scan ? lowbit : '0;
        out_idx    = is_scan ? idx_v : '0;
        out_last   = is_scan && (rest == '0);
        done       = done_q;
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    if (load_data != '0) begin
                        rem_d   = load_data;
                        state_d = SCAN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_ready) begin
                    rem_d = rem_q & ~lowbit;
                    if (rest == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef BITOPS_SCAN_ABORT_EN
        // Abort wins over a same-cycle handshake; that entry is dropped, not consumed.
        if (is_scan && abort) begin
            rem_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_bitops_scan_lo_enc.sv
// tb/tb_bitops_scan_lo_enc.sv - directed self-checking bench for bitops_scan_lo_enc
module tb_bitops_scan_lo_enc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic [7:0] out_onehot;
    logic       out_last;
    logic       done;
`ifdef BITOPS_SCAN_ABORT_EN
    logic       abort;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bitops_scan_lo_enc #(.width(8), .idxw(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
`ifdef BITOPS_SCAN_ABORT_EN
        .abort      (abort),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_last   (out_last),
        .done       (done)
    );

    task automatic test_reset();
        rst_n = 1'b0; load_valid = 1'b0; load_data = 8'h00; out_ready = 1'b0;
`ifdef BITOPS_SCAN_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b want 1", load_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
        checks++; if (out_onehot !== 8'h00) begin errors++; $display("FAIL reset_out_onehot got %h want 00", out_onehot); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_scan();
        logic [2:0] exp_idx [3] = '{3'd2, 3'd5, 3'd7};
        logic [7:0] exp_oh  [3] = '{8'h04, 8'h20, 8'h80};
        load_valid = 1'b1; load_data = 8'hA4; out_ready = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %b want 1", k, out_valid); end
            checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL basic_load_ready[%0d] got %b want 0", k, load_ready); end
            checks++; if (out_idx !== exp_idx[k]) begin errors++; $display("FAIL basic_idx[%0d] got %0d want %0d", k, out_idx, exp_idx[k]); end
            checks++; if (out_onehot !== exp_oh[k]) begin errors++; $display("FAIL basic_onehot[%0d] got %h want %h", k, out_onehot, exp_oh[k]); end
            checks++; if (out_last !== (k == 2)) begin errors++; $display("FAIL basic_last[%0d] got %b want %b", k, out_last, (k == 2)); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early[%0d] got %b want 0", k, done); end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after got %b want 0", out_valid); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_after got %b want 1", load_ready); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done); end
    endtask

    task automatic test_zero_mask();
        load_valid = 1'b1; load_data = 8'h00;
        @(negedge clk);
        load_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid got %b want 0", out_valid); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", load_ready); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b want 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_valid2 got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        int e = 0;
        int cyc = 0;
        load_valid = 1'b1; load_data = 8'hFF; out_ready = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        while (e < 8 && cyc < 40) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[c%0d] got %b want 1", cyc, out_valid); end
            checks++; if (out_idx !== 3'(e)) begin errors++; $display("FAIL stall_idx[c%0d] got %0d want %0d", cyc, out_idx, e); end
            checks++; if (out_onehot !== (8'h01 << e)) begin errors++; $display("FAIL stall_onehot[c%0d] got %h want %h", cyc, out_onehot, 8'h01 << e); end
            checks++; if (out_last !== (e == 7)) begin errors++; $display("FAIL stall_last[c%0d] got %b want %b", cyc, out_last, (e == 7)); end
            out_ready = (cyc % 3 == 0);
            if (out_ready) e++;
            cyc++;
            @(negedge clk);
        end
        checks++; if (e != 8) begin errors++; $display("FAIL stall_drain got %0d entries want 8", e); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %b want 1", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_after got %b want 0", out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        load_valid = 1'b1; load_data = 8'h81; out_ready = 1'b1;
        @(negedge clk);
        load_data = 8'h02;
        checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL b2b_idx0 got %0d want 0", out_idx); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_scan got %b want 0", load_ready); end
        @(negedge clk);
        checks++; if (out_idx !== 3'd7) begin errors++; $display("FAIL b2b_idx7 got %0d want 7", out_idx); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL b2b_last7 got %b want 1", out_last); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_done got %b want 1", load_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_done got %b want 0", out_valid); end
        @(negedge clk);
        load_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %b want 1", out_valid); end
        checks++; if (out_idx !== 3'd1) begin errors++; $display("FAIL b2b_second_idx got %0d want 1", out_idx); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL b2b_second_last got %b want 1", out_last); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_second_done got %b want 0", done); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done_pulse got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        load_valid = 1'b1; load_data = 8'h0F; out_ready = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL rmid_idx0 got %0d want 0", out_idx); end
        @(negedge clk);
        checks++; if (out_idx !== 3'd1) begin errors++; $display("FAIL rmid_idx1 got %0d want 1", out_idx); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", out_valid); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", load_ready); end
        checks++; if (out_onehot !== 8'h00) begin errors++; $display("FAIL rmid_onehot got %h want 00", out_onehot); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rmid_last got %b want 0", out_last); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b want 0", done); end
        rst_n = 1'b1;
        load_valid = 1'b1; load_data = 8'h10;
        @(negedge clk);
        load_valid = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done2 got %b want 0", done); end
        checks++; if (out_idx !== 3'd4) begin errors++; $display("FAIL rmid_idx4 got %0d want 4", out_idx); end
        checks++; if (out_onehot !== 8'h10) begin errors++; $display("FAIL rmid_onehot4 got %h want 10", out_onehot); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL rmid_last4 got %b want 1", out_last); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rmid_done_pulse got %b want 1", done); end
        @(negedge clk);
    endtask

`ifdef BITOPS_SCAN_ABORT_EN
    task automatic test_abort();
        load_valid = 1'b1; load_data = 8'hF0; out_ready = 1'b1; abort = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        checks++; if (out_idx !== 3'd4) begin errors++; $display("FAIL abort_idx4 got %0d want 4", out_idx); end
        @(negedge clk);
        checks++; if (out_idx !== 3'd5) begin errors++; $display("FAIL abort_idx5 got %0d want 5", out_idx); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", out_valid); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_done got %b want 1", done); end
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", load_ready); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_idle_done got %b want 0", done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_idle_valid got %b want 0", out_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_scan();
        test_zero_mask();
        test_stall();
        test_back_to_back();
        test_reset_mid_scan();
`ifdef BITOPS_SCAN_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
